// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready/data in, downstream
// valid/ready/data out, plus the occupancy and transfer-count status outputs.
interface pipe_skid_stage_if #(
    parameter int DW = 1,
    parameter int CW = 16
) ();
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [1:0]    o_count;
    logic [CW-1:0] o_xfer_cnt;

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_count, o_xfer_cnt
    );

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_count, o_xfer_cnt
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline stage; upstream ready comes only from the state
// register, so downstream back-pressure never reaches it combinationally.
//
// state | meaning
// EMPTY | no entry held, o_valid low
// BUSY  | one entry in the main register
// FULL  | main holds the older entry, skid holds the younger; o_ready low
module pipe_skid_stage #(
    parameter int DW = 1,
    parameter int CW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pipe_skid_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mreg_q, mreg_d;
    logic [DW-1:0] sreg_q, sreg_d;
    logic [CW-1:0] xfer_q, xfer_d;
    logic          in_fire;
    logic          out_fire;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            mreg_q  <= '0;
            sreg_q  <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            mreg_q  <= mreg_d;
            sreg_q  <= sreg_d;
            xfer_q  <= xfer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mreg_d   = mreg_q;
        sreg_d   = sreg_q;
        in_fire  = bus.i_valid & (state_q != FULL);
        out_fire = bus.i_ready & (state_q != EMPTY);
        xfer_d   = out_fire ? xfer_q + CW'(1) : xfer_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    mreg_d  = bus.i_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    mreg_d = bus.i_data;
                end else if (in_fire) begin
                    sreg_d  = bus.i_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    mreg_d  = sreg_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign bus.o_ready    = (state_q != FULL) & ~i_rst;
    assign bus.o_valid    = (state_q != EMPTY);
    assign bus.o_data     = mreg_q;
    assign bus.o_xfer_cnt = xfer_q;
    assign bus.o_count    = (state_q == FULL) ? 2'd2 :
                            (state_q == BUSY) ? 2'd1 : 2'd0;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboarded bench for pipe_skid_stage: an 8-bit instance for the
// main sequence and a 1-bit instance with a 2-bit counter for the wrap case.
module tb_pipe_skid_stage;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 i_clk = ~i_clk;

    pipe_skid_stage_if #(.DW(8), .CW(16)) bus ();
    pipe_skid_stage_if #(.DW(1), .CW(2))  bw ();

    pipe_skid_stage #(.DW(8), .CW(16)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    pipe_skid_stage #(.DW(1), .CW(2)) dut_w (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bw)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    logic [7:0] q[$];
    int         exp_x;
    logic       in_f, out_f, last_in;
    int         guard;

    initial begin
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hAA;
        bus.i_ready = 1'b0;
        bw.i_valid  = 1'b0;
        bw.i_data   = 1'b0;
        bw.i_ready  = 1'b0;

        // Reset held for two edges with valid data offered
        tick();
        chk("rst1_valid", bus.o_valid, 0);
        chk("rst1_ready", bus.o_ready, 0);
        chk("rst1_count", bus.o_count, 0);
        chk("rst1_xfer",  bus.o_xfer_cnt, 0);
        tick();
        chk("rst2_valid", bus.o_valid, 0);
        chk("rst2_ready", bus.o_ready, 0);
        chk("rst2_data",  bus.o_data, 0);
        i_rst = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        chk("rel_ready", bus.o_ready, 1);
        tick();
        chk("rel_valid", bus.o_valid, 0);

        // Streaming at full rate
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus.i_data = 8'(k);
            tick();
            chk("strm_data",  bus.o_data, k);
            chk("strm_valid", bus.o_valid, 1);
            chk("strm_count", bus.o_count, 1);
        end
        bus.i_valid = 1'b0;
        tick();
        chk("strm_end_count", bus.o_count, 0);
        chk("strm_end_xfer",  bus.o_xfer_cnt, 10);

        // Back-pressure
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h11;
        tick();
        chk("bp_data11", bus.o_data, 8'h11);
        chk("bp_cnt1",   bus.o_count, 1);
        bus.i_data = 8'h22;
        tick();
        chk("bp_cnt2",   bus.o_count, 2);
        chk("bp_ready0", bus.o_ready, 0);
        chk("bp_hold11", bus.o_data, 8'h11);
        bus.i_data = 8'h33;
        tick();
        chk("bp_rej_cnt",  bus.o_count, 2);
        chk("bp_rej_data", bus.o_data, 8'h11);
        chk("bp_rej_vld",  bus.o_valid, 1);
        bus.i_ready = 1'b1;
        tick();
        chk("bp_out22",  bus.o_data, 8'h22);
        chk("bp_cnt_a",  bus.o_count, 1);
        tick();
        chk("bp_out33",  bus.o_data, 8'h33);
        chk("bp_cnt_b",  bus.o_count, 1);
        bus.i_valid = 1'b0;
        tick();
        chk("bp_empty",  bus.o_count, 0);
        chk("bp_xfer",   bus.o_xfer_cnt, 13);

        // Drain from FULL
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h44;
        tick();
        bus.i_data  = 8'h55;
        tick();
        chk("dr_full", bus.o_count, 2);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        chk("dr_d44", bus.o_data, 8'h44);
        tick();
        chk("dr_d55", bus.o_data, 8'h55);
        chk("dr_c1",  bus.o_count, 1);
        tick();
        chk("dr_vld0", bus.o_valid, 0);
        chk("dr_c0",   bus.o_count, 0);
        tick();
        chk("dr_c0b",  bus.o_count, 0);
        chk("dr_xfer", bus.o_xfer_cnt, 15);

        // Random traffic against a queue model; upstream holds data until taken
        exp_x   = 15;
        last_in = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!(bus.i_valid && !last_in)) begin
                bus.i_valid = 1'($urandom_range(0, 1));
                bus.i_data  = 8'($urandom);
            end
            bus.i_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_ready", bus.o_ready, (q.size() < 2) ? 1 : 0);
            chk("rnd_valid", bus.o_valid, (q.size() > 0) ? 1 : 0);
            chk("rnd_count", bus.o_count, q.size());
            if (q.size() > 0) chk("rnd_data", bus.o_data, q[0]);
            in_f  = bus.i_valid & (q.size() < 2);
            out_f = bus.i_ready & (q.size() > 0);
            tick();
            if (out_f) begin
                void'(q.pop_front());
                exp_x++;
            end
            if (in_f) q.push_back(bus.i_data);
            last_in = in_f;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 3) begin
            #1;
            chk("rnd_drain", bus.o_data, q[0]);
            tick();
            void'(q.pop_front());
            exp_x++;
            guard++;
        end
        chk("rnd_left",  q.size(), 0);
        chk("rnd_empty", bus.o_count, 0);
        chk("rnd_xfer",  bus.o_xfer_cnt, exp_x & 16'hFFFF);

        // Reset while FULL
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h77;
        tick();
        bus.i_data  = 8'h88;
        tick();
        chk("mr_full", bus.o_count, 2);
        bus.i_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        chk("mr_count", bus.o_count, 0);
        chk("mr_valid", bus.o_valid, 0);
        chk("mr_ready", bus.o_ready, 0);
        chk("mr_xfer",  bus.o_xfer_cnt, 0);
        i_rst = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr_novalid", bus.o_valid, 0);
        end
        chk("mr_xfer_idle", bus.o_xfer_cnt, 0);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h66;
        tick();
        bus.i_valid = 1'b0;
        chk("mr_new66", bus.o_data, 8'h66);
        tick();
        chk("mr_after", bus.o_valid, 0);
        chk("mr_xfer1", bus.o_xfer_cnt, 1);

        // Counter wrap on the narrow instance: out_fire count after n edges is n-1
        bw.i_valid = 1'b1;
        bw.i_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            bw.i_data = 1'(n);
            tick();
            chk("w_data", bw.o_data, n & 1);
            chk("w_xfer", bw.o_xfer_cnt, (n - 1) % 4);
        end
        bw.i_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
